// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480 @ 60 Hz timing constants, the coordinate type and the scan
// region decode. The graphics stage imports the same package for its board
// offset arithmetic, so both sides agree on the geometry.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef logic [COORD_W-1:0] coord_t;

   // The four parts of a scan line (or of a frame, counted in lines).
   typedef enum logic [1:0] {
      REGION_ACTIVE,
      REGION_FP,
      REGION_SYNC,
      REGION_BP
   } region_e;

   // Classify a counter value; the back porch is whatever remains up to TOTAL-1.
   function automatic region_e scan_region(input int unsigned cnt,
                                           input int unsigned active,
                                           input int unsigned fp,
                                           input int unsigned sync);
      region_e r;
      if (cnt < active)                  r = REGION_ACTIVE;
      else if (cnt < active + fp)        r = REGION_FP;
      else if (cnt < active + fp + sync) r = REGION_SYNC;
      else                               r = REGION_BP;
      return r;
   endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// -----------------------------------------------------------------------------
// pixel_tick_div
// Divides the system clock down to the pixel rate. A counter runs
// 0..CLK_DIV-1 and wraps; pix_tick is the combinational decode of the last
// count, so it is high for exactly one clk in every CLK_DIV.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (counter clears to 0)
//   pix_tick out  one-clk strobe per pixel period
// -----------------------------------------------------------------------------
module pixel_tick_div
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   output logic pix_tick
);

   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("pixel_tick_div: CLK_DIV must be at least 2");
   end

   logic [DIV_W-1:0] div;

   // NOTE: clocked state is assigned with <= so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              div <= '0;
      else if (div == DIV_LAST)  div <= '0;
      else                       div <= div + DIV_W'(1);
   end

   // Low throughout reset because div is held at 0 and CLK_DIV >= 2.
   assign pix_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Display-timing front end: pixel-rate strobe, horizontal/vertical scan
// counters and the registered decodes the renderer and VGA connector use.
//
// Ports
//   clk          in   system clock, the only clock
//   reset_n      in   asynchronous active-low reset
//   pix_tick     out  one-clk strobe per pixel period (unregistered decode)
//   coord_x      out  horizontal scan position 0..H_TOTAL-1 (raw, incl. blanking)
//   coord_y      out  vertical scan position 0..V_TOTAL-1 (raw, incl. blanking)
//   active_area  out  coord_x < H_ACTIVE and coord_y < V_ACTIVE
//   hsync        out  horizontal sync at level SYNC_POL while asserted
//   vsync        out  vertical sync at level SYNC_POL while asserted
//   line_start   out  one-clk pulse in the first cycle coord_x shows 0
//   frame_start  out  one-clk pulse in the first cycle (coord_x,coord_y) shows (0,0)
//
// All outputs other than pix_tick are registered together one clk behind the
// counters, so every output describes the same pixel in the same cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic   clk,
   input  logic   reset_n,
   output logic   pix_tick,
   output coord_t coord_x,
   output coord_t coord_y,
   output logic   active_area,
   output logic   hsync,
   output logic   vsync,
   output logic   line_start,
   output logic   frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL does not fit the coordinate width");
   end
   if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL does not fit the coordinate width");
   end

   // Wraps are explicit compares against TOTAL-1, never reliance on 2^10 rollover.
   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

   // --------------------------------------------------------------------------
   // Pixel-rate strobe
   // --------------------------------------------------------------------------
   pixel_tick_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .pix_tick (pix_tick)
   );

   // --------------------------------------------------------------------------
   // Scan counters
   // --------------------------------------------------------------------------
   coord_t h_cnt;
   coord_t v_cnt;
   logic   h_wrap;
   logic   v_wrap;

   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_wrap) begin
            h_cnt <= '0;
            if (v_wrap) v_cnt <= '0;
            else        v_cnt <= v_cnt + coord_t'(1);
         end else begin
            h_cnt <= h_cnt + coord_t'(1);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Region decode
   // --------------------------------------------------------------------------
   region_e h_region;
   region_e v_region;

   assign h_region = scan_region(32'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
   assign v_region = scan_region(32'(v_cnt), V_ACTIVE, V_FP, V_SYNC);

   // --------------------------------------------------------------------------
   // Output register
   // --------------------------------------------------------------------------
   // counters_moved is high in the cycle right after a pix_tick, i.e. the
   // first cycle the counters hold a new pixel. Gating the start pulses with it
   // keeps them one clk wide and suppresses a pulse for the post-reset (0,0).
   logic counters_moved;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counters_moved <= 1'b0;
         coord_x        <= '0;
         coord_y        <= '0;
         active_area    <= 1'b0;
         hsync          <= ~SYNC_POL;
         vsync          <= ~SYNC_POL;
         line_start     <= 1'b0;
         frame_start    <= 1'b0;
      end else begin
         counters_moved <= pix_tick;
         coord_x        <= h_cnt;
         coord_y        <= v_cnt;
         active_area    <= (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE);
         hsync          <= (h_region == REGION_SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync          <= (v_region == REGION_SYNC) ? SYNC_POL : ~SYNC_POL;
         line_start     <= counters_moved && (h_cnt == '0);
         frame_start    <= counters_moved && (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Display-timing front end for the snake game video path. Divides the system clock down to the pixel rate and runs horizontal/vertical scan counters for 640x480 @ 60 Hz. Produces `coord_x`, `coord_y` and `active_area`, which the graphics/renderer stage consumes to compute `rgb`, plus `hsync`/`vsync` for the VGA connector. Its `frame_start` pulse is the frame-synchronous event the game logic uses for tearing-free state updates.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz to 25 MHz); legal range 2..16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync asserted level (0 = active-low, the VGA 640x480 standard).
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pix_tick`  out  1  one-`clk` strobe per pixel period.
- `coord_x`  out  10  horizontal scan position, 0..H_TOTAL-1.
- `coord_y`  out  10  vertical scan position, 0..V_TOTAL-1.
- `active_area`  out  1  high when `coord_x < H_ACTIVE` and `coord_y < V_ACTIVE`.
- `hsync`  out  1  horizontal sync, at polarity `SYNC_POL`.
- `vsync`  out  1  vertical sync, at polarity `SYNC_POL`.
- `line_start`  out  1  one-`clk` pulse when `coord_x` becomes 0.
- `frame_start`  out  1  one-`clk` pulse when (`coord_x`,`coord_y`) becomes (0,0).

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pix_tick` is a decode of `div == CLK_DIV-1`.
- Counter `h_cnt` (10 b) increments on `pix_tick` and wraps H_TOTAL-1 -> 0.
- Counter `v_cnt` (10 b) increments only on a `pix_tick` where `h_cnt` wraps, and itself wraps V_TOTAL-1 -> 0.
- There is no explicit FSM. The four scan regions (active, front porch, sync, back porch) are decodes of the counters.
- hsync is asserted (= SYNC_POL) for `h_cnt` in [656, 752). vsync is asserted for `v_cnt` in [490, 492). Otherwise both are driven to ~SYNC_POL.
- `coord_x`/`coord_y` carry the raw counters, including during blanking. Consumers must gate on `active_area`.
- Width rule: elaboration fails if H_TOTAL > 1024, V_TOTAL > 1024, or CLK_DIV < 2. No saturating arithmetic; wraps are explicit compares to the TOTAL-1 values, never modulo-2^10.

## Timing
- All outputs except `pix_tick` are registered decodes of `h_cnt`/`v_cnt`. They lag the counters by exactly 1 `clk` and are mutually consistent: the same pixel is described in the same cycle.
- Each pixel value is held for CLK_DIV `clk` cycles. The first cycle of a new pixel value is the cycle after the `pix_tick` that advanced it, plus 1 for the output register.
- `line_start` and `frame_start` are high for exactly 1 `clk`, in the first cycle the outputs show `coord_x == 0` (respectively (0,0)).
- Reset values while `reset_n` = 0:
  - `div`, `h_cnt`, `v_cnt` = 0.
  - `coord_x` = `coord_y` = 0.
  - `active_area` = 0, `pix_tick` = 0, `line_start` = `frame_start` = 0.
  - `hsync` = `vsync` = ~SYNC_POL.
- After reset release:
  - The counters sit at (0,0) immediately. `active_area` rises 1 `clk` after release. `frame_start` does not pulse for this initial (0,0).
  - The first `pix_tick` occurs on the CLK_DIV-th `clk` edge after release.
- Reset asserted mid-frame: all state clears asynchronously. The scan restarts at (0,0) and no partial sync pulse is extended.
- Frame period = CLK_DIV × 800 × 525 = 1,680,000 `clk` (60 Hz at 100 MHz).

## Structure
- Shared package `vga_timing_pkg` holds the 640x480 timing constants, H_TOTAL/V_TOTAL, and the 10-bit coordinate width. The graphics stage imports the same package for its board-offset arithmetic.
- One natural sub-module: `pixel_tick_div`, parameterised by CLK_DIV, with outputs `pix_tick` and reset `reset_n`.
- Remaining logic (counters and output decode/register) stays in `vga_timing_gen`.

## Test plan
- Reset then release, default parameters: outputs hold their reset values for the whole reset. `pix_tick` first high on the 4th edge after release. `active_area` = 1 one `clk` after release.
- Run one line: hsync is low for exactly 96 × 4 = 384 `clk`, starting when `coord_x` = 656. `active_area` falls when `coord_x` becomes 640. `line_start` pulses once per 3200 `clk`.
- Run one full frame: `vsync` is low for 2 lines (6400 `clk`), starting at `coord_y` = 490. `coord_y` wraps 524 -> 0 with `frame_start` pulsing for 1 `clk`. The spacing between successive `frame_start` pulses is 1,680,000 `clk`.
- Wrap boundary: at (799,524) the next pixel is (0,0); `coord_x` never reads 800 and `coord_y` never reads 525.
- Reset asserted at `coord_x` = 700 (hsync active): `hsync` returns to 1 asynchronously, before the next edge. After release the scan resumes from (0,0).
- Alternate parameters CLK_DIV = 2 and SYNC_POL = 1: `pix_tick` fires every 2 `clk`. Sync pulses are high-active with unchanged pixel widths.
